// File: rtl/rel_stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : rel_stream_demux
//  Description : Steers a host read-response stream to N_REL relation output
//                streams. Beat counts and routing come from a request
//                metadata queue. tlast is regenerated per request
//                (LAST_MODE=0) or per relation pass (LAST_MODE=1).
//                Optional per-channel statistics under RDEMUX_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rel_stream_demux #(
  parameter int N_REL     = 2,
  parameter int DATA_W    = 512,
  parameter int BEAT_W    = 16,
  parameter int REQ_DEPTH = 8,
  parameter int LAST_MODE = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(N_REL)-1:0]    req_rel,
  input  logic [BEAT_W-1:0]           req_beats,
  input  logic                        req_final,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic [N_REL-1:0]            m_axis_tvalid,
  input  logic [N_REL-1:0]            m_axis_tready,
  output logic [N_REL*DATA_W-1:0]     m_axis_tdata,
  output logic [N_REL-1:0]            m_axis_tlast,
  output logic                        done_valid,
  output logic [$clog2(N_REL)-1:0]    done_rel,
`ifdef RDEMUX_STATS_EN
  input  logic [$clog2(N_REL)-1:0]    stat_sel,
  output logic [31:0]                 stat_beats,
  output logic [31:0]                 stat_reqs,
`endif
  output logic                        err_len
);

  localparam int REL_W = $clog2(N_REL);
  localparam int AW    = $clog2(REQ_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(REQ_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Request queue storage and pointers
  logic [REL_W-1:0]  fifo_rel_q   [REQ_DEPTH];
  logic [BEAT_W-1:0] fifo_beats_q [REQ_DEPTH];
  logic              fifo_final_q [REQ_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              req_ready_q;
  logic              push_w;
  logic              pop_w;

  // Sequencer state
  state_t            state_q;
  logic [REL_W-1:0]  cur_rel_q;
  logic [BEAT_W-1:0] rem_q;
  logic              cur_final_q;
  logic              done_valid_q;
  logic [REL_W-1:0]  done_rel_q;
  logic              err_len_q;

  // Per-channel output registers
  logic [N_REL-1:0]        out_v_q;
  logic [N_REL-1:0]        out_last_q;
  logic [N_REL*DATA_W-1:0] out_data_q;

  logic accept_w;
  logic last_beat_w;
  logic beat_last_w;
  logic s_ready_w;

  assign push_w = req_valid && req_ready_q;
  assign pop_w  = (state_q == ST_IDLE) && (count_q != '0);

  // Host is only accepted while streaming and the target register can take a beat
  assign s_ready_w   = (state_q == ST_STREAM) &&
                       (!out_v_q[cur_rel_q] || m_axis_tready[cur_rel_q]);
  assign accept_w    = s_ready_w && s_axis_tvalid;
  assign last_beat_w = (rem_q == BEAT_W'(1));
  assign beat_last_w = (LAST_MODE == 0) ? last_beat_w : (last_beat_w && cur_final_q);

  assign req_ready     = req_ready_q;
  assign s_axis_tready = s_ready_w;
  assign m_axis_tvalid = out_v_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign done_valid    = done_valid_q;
  assign done_rel      = done_rel_q;
  assign err_len       = err_len_q;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q + (AW+1)'(push_w) - (AW+1)'(pop_w);
  end

  // Queue payload storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (push_w) begin
      fifo_rel_q[wr_ptr_q]   <= req_rel;
      fifo_beats_q[wr_ptr_q] <= req_beats;
      fifo_final_q[wr_ptr_q] <= req_final;
    end
  end

  // Queue pointers, occupancy and registered not-full flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      req_ready_q <= (count_d != DEPTH_CNT);
    end
  end

  // Request sequencer: pop a request in IDLE, count its beats in STREAM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_rel_q    <= '0;
      rem_q        <= '0;
      cur_final_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_rel_q   <= '0;
      err_len_q    <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_w) begin
            cur_rel_q   <= fifo_rel_q[rd_ptr_q];
            rem_q       <= fifo_beats_q[rd_ptr_q];
            cur_final_q <= fifo_final_q[rd_ptr_q];
            if (fifo_beats_q[rd_ptr_q] == '0) begin
              // Empty request completes immediately without touching the host
              done_valid_q <= 1'b1;
              done_rel_q   <= fifo_rel_q[rd_ptr_q];
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (accept_w) begin
            rem_q <= rem_q - BEAT_W'(1);
            if (s_axis_tlast != last_beat_w) err_len_q <= 1'b1;
            if (last_beat_w) begin
              done_valid_q <= 1'b1;
              done_rel_q   <= cur_rel_q;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output valid/last per channel; unselected channels drain on their own ready
  always_ff @(posedge clock) begin
    if (reset) begin
      out_v_q    <= '0;
      out_last_q <= '0;
    end else begin
      for (int i = 0; i < N_REL; i++) begin
        if (accept_w && (cur_rel_q == REL_W'(i))) begin
          out_v_q[i]    <= 1'b1;
          out_last_q[i] <= beat_last_w;
        end else if (m_axis_tready[i]) begin
          out_v_q[i] <= 1'b0;
        end
      end
    end
  end

  // Output data per channel; only loaded on an accepted beat, so it holds while stalled
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REL; i++) begin
      if (accept_w && (cur_rel_q == REL_W'(i))) begin
        out_data_q[i*DATA_W +: DATA_W] <= s_axis_tdata;
      end
    end
  end

`ifdef RDEMUX_STATS_EN
  logic [31:0] cnt_beats_q [N_REL];
  logic [31:0] cnt_reqs_q  [N_REL];
  logic [31:0] stat_beats_q;
  logic [31:0] stat_reqs_q;

  assign stat_beats = stat_beats_q;
  assign stat_reqs  = stat_reqs_q;

  // Per-channel handoff and completion counters, wrapping at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_REL; i++) begin
        cnt_beats_q[i] <= '0;
        cnt_reqs_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REL; i++) begin
        if (out_v_q[i] && m_axis_tready[i]) cnt_beats_q[i] <= cnt_beats_q[i] + 32'd1;
        if (done_valid_q && (done_rel_q == REL_W'(i))) cnt_reqs_q[i] <= cnt_reqs_q[i] + 32'd1;
      end
    end
  end

  // Registered readback of the selected channel's counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_beats_q <= '0;
      stat_reqs_q  <= '0;
    end else if (32'(stat_sel) < N_REL) begin
      stat_beats_q <= cnt_beats_q[stat_sel];
      stat_reqs_q  <= cnt_reqs_q[stat_sel];
    end else begin
      stat_beats_q <= '0;
      stat_reqs_q  <= '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/rel_stream_demux.md
Name: rel_stream_demux

Overview:
- Parametrised N-relation successor to the fixed two-relation (R/S) host-read splitter in the stream join user logic.
- Takes one host sink stream that carries the responses to ordered bypass read requests. Each beat is steered to one of N_REL relation output streams.
- Beat counts come from a request metadata queue. tlast is regenerated per request, or per relation pass, depending on LAST_MODE.
- Sits between the bypass-read request issuer and the per-relation query pipelines (top_r/top_s style consumers).

Parameters:
- N_REL, 2, number of relation output channels (2..8).
- DATA_W, 512, stream data width in bits.
- BEAT_W, 16, width of the per-request beat count.
- REQ_DEPTH, 8, request queue depth (power of 2).
- LAST_MODE, 0, 0 = output tlast on the final beat of every request; 1 = output tlast only on the final beat of a request pushed with req_final=1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request push
- req_ready  out  1  request queue not full
- req_rel  in  $clog2(N_REL)  target relation index
- req_beats  in  BEAT_W  number of host beats for this request
- req_final  in  1  last request of this relation pass (used when LAST_MODE=1)
- s_axis_tvalid  in  1  host data valid
- s_axis_tready  out  1  host data accept
- s_axis_tdata  in  DATA_W  host data
- s_axis_tlast  in  1  host tlast (checked only, never forwarded)
- m_axis_tvalid  out  N_REL  per-relation valid
- m_axis_tready  in  N_REL  per-relation ready
- m_axis_tdata  out  N_REL*DATA_W  per-relation data; channel i occupies [i*DATA_W +: DATA_W]
- m_axis_tlast  out  N_REL  per-relation regenerated tlast
- done_valid  out  1  one-cycle pulse when a request completes
- done_rel  out  $clog2(N_REL)  relation of the completed request
- err_len  out  1  sticky host-tlast mismatch flag

Behaviour:
- Clock/reset: one clock, `clock`; reset is synchronous and active-high.
- Reset state: all outputs 0 (req_ready, s_axis_tready, m_axis_tvalid, done_valid, err_len); request queue emptied; FSM to IDLE.
- Reset mid-stream: any in-flight request and any held output beats are discarded.
- Request queue: REQ_DEPTH-entry FIFO of {rel, beats, final}.
  - req_ready = !full.
  - A push is accepted when req_valid && req_ready.
  - A push and a pop in the same cycle while full is not allowed, because req_ready is already 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - If the queue is non-empty, pop it and load cur_rel, rem = beats, cur_final.
  - If beats == 0: pulse done_valid with done_rel = rel, produce no output beat, stay in IDLE.
  - Otherwise go to STREAM.
  - s_axis_tready = 0 in IDLE. This gives a 1-cycle bubble between requests.
- STREAM:
  - s_axis_tready = !out_v[cur_rel] || m_axis_tready[cur_rel].
  - On each accepted beat: write the beat into output register cur_rel and decrement rem.
  - When the accepted beat has rem == 1: pulse done_valid next cycle with done_rel = cur_rel, and go to IDLE.
- Output stage: one register per channel.
  - Latency is 1 cycle from host accept to m_axis_tvalid.
  - Full throughput when the consumer holds ready high.
  - tvalid stays high until ready.
  - tdata/tlast are stable while valid && !ready.
  - Non-selected channels keep draining independently.
- tlast generation:
  - LAST_MODE=0: tlast = (rem == 1).
  - LAST_MODE=1: tlast = (rem == 1) && cur_final.
- err_len: set when an accepted beat has s_axis_tlast != (rem == 1). Cleared only by reset. Data flow is unaffected.
- Host beats arriving while in IDLE stall (tready = 0). They are never dropped.
- rem arithmetic: BEAT_W-bit, no wrap; a request can carry at most 2^BEAT_W-1 beats.

Optional Feature:
- Macro: RDEMUX_STATS_EN.
- When defined, adds these ports:
  - stat_sel  in  $clog2(N_REL)
  - stat_beats  out  32
  - stat_reqs  out  32
- Per-channel 32-bit counters: output beats handed off (tvalid && tready) and requests completed.
  - stat_* outputs are registered, read from the channel selected by stat_sel, 1-cycle latency.
  - Counters wrap at 2^32 and clear on reset.
- When not defined: no counters and no stat ports.

Test Plan:
- Two requests pushed {rel0, 4 beats} then {rel1, 3 beats}, host streams 7 beats with ready all 1 -> ch0 gets beats 0–3 with tlast on beat 3; ch1 gets beats 4–6 with tlast on beat 6; done_valid pulses twice with rel 0 then rel 1; one bubble cycle between the requests.
- m_axis_tready[0] = 0 for 5 cycles mid-request -> s_axis_tready drops after one held beat; no data is lost or duplicated; tdata stays stable while stalled.
- {rel1, 0 beats} pushed -> done_valid pulses with done_rel = 1; no m_axis activity; host is not accepted.
- LAST_MODE=1 with {rel0, 2 beats, final 0} then {rel0, 2 beats, final 1} -> ch0 tlast asserted only on the 4th beat.
- Host tlast asserted on beat 2 of a 4-beat request -> err_len = 1 and stays 1; all 4 beats are forwarded normally; reset clears err_len.
- Assert reset during beat 2 of an 8-beat request -> all outputs 0 next cycle and the queue is empty; a new {rel0, 1 beat} request then completes normally.
